// File: rtl/prm_pkg.sv
// Shared definitions for the PRM edge-mask generator: default geometry,
// FSM state encoding and the read-tag payload.
package prm_pkg;

  localparam int unsigned PRM_XW  = 4;
  localparam int unsigned PRM_YW  = 5;
  localparam int unsigned PRM_ZW  = 5;
  localparam int unsigned PRM_CW  = 3;
  localparam int unsigned PRM_NCH = 8;
  localparam int unsigned PRM_MW  = 512;
  localparam int unsigned PRM_DCW = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EMIT  = 2'd3
  } prm_state_e;

  // Travels alongside each memory read so the returning word finds its chunk slot
  typedef struct packed {
    logic              en;
    logic [PRM_CW-1:0] chunk;
  } prm_tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/prm_tag_pipe.sv
// Fixed-depth shift register carrying the read tag so it emerges in the same
// cycle as the memory read data it belongs to.
module prm_tag_pipe
  import prm_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     CLK,
  input  logic     RST_n,
  input  prm_tag_t tag_in,
  output prm_tag_t tag_out
);

  prm_tag_t stage_q [DEPTH];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/prm_edge_mask_gen.sv
// Fetches each voxel's edge-collision mask as NCH memory words and presents
// the whole mask for exactly one cycle; chunk outputs are zero otherwise.
module prm_edge_mask_gen
  import prm_pkg::*;
#(
  parameter int unsigned XW     = PRM_XW,
  parameter int unsigned YW     = PRM_YW,
  parameter int unsigned ZW     = PRM_ZW,
  parameter int unsigned MW     = PRM_MW,
  parameter int unsigned NCH    = PRM_NCH,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic                          vox_valid,
  output logic                          vox_ready,
  input  logic [XW+YW+ZW-1:0]           vox_xyz,
  output logic                          mem_en,
  output logic [XW+YW+ZW+PRM_CW-1:0]    mem_addr,
  input  logic [MW-1:0]                 mem_rdata,
  output logic [MW-1:0]                 edge_mask_512p0,
  output logic [MW-1:0]                 edge_mask_512p1,
  output logic [MW-1:0]                 edge_mask_512p2,
  output logic [MW-1:0]                 edge_mask_512p3,
  output logic [MW-1:0]                 edge_mask_512p4,
  output logic [MW-1:0]                 edge_mask_512p5,
  output logic [MW-1:0]                 edge_mask_512p6,
  output logic [MW-1:0]                 edge_mask_512p7,
  output logic                          mask_valid,
  output logic                          busy,
  output logic [15:0]                   vox_cnt
);

  localparam int unsigned VW  = XW + YW + ZW;
  localparam int unsigned CW  = PRM_CW;
  localparam int unsigned DCW = PRM_DCW;

  prm_state_e      state_q;
  logic [VW-1:0]   xyz_q;
  logic [CW-1:0]   chunk_idx_q;
  logic [DCW-1:0]  drain_q;
  logic [MW-1:0]   chunk_q     [NCH];
  logic [MW-1:0]   chunk_fwd_c [NCH];
  logic [MW-1:0]   mask_q      [NCH];
  prm_tag_t        tag_in;
  prm_tag_t        tag_out;

  assign tag_in.en    = mem_en;
  assign tag_in.chunk = mem_addr[CW-1:0];

  prm_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Capture returning words into their chunk slots, independent of FSM state
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k < int'(NCH); k++) chunk_q[k] <= '0;
    end else if (tag_out.en) begin
      chunk_q[tag_out.chunk] <= mem_rdata;
    end
  end

  // The last word lands in the same cycle the mask is loaded, so forward it
  always_comb begin
    for (int k = 0; k < int'(NCH); k++) begin
      chunk_fwd_c[k] = chunk_q[k];
      if (tag_out.en && (tag_out.chunk == CW'(k))) chunk_fwd_c[k] = mem_rdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      vox_ready   <= 1'b1;
      busy        <= 1'b0;
      mem_en      <= 1'b0;
      mem_addr    <= '0;
      mask_valid  <= 1'b0;
      vox_cnt     <= '0;
      xyz_q       <= '0;
      chunk_idx_q <= '0;
      drain_q     <= '0;
      for (int k = 0; k < int'(NCH); k++) mask_q[k] <= '0;
    end else begin
      mask_valid <= 1'b0;
      for (int k = 0; k < int'(NCH); k++) mask_q[k] <= '0;
      case (state_q)
        ST_IDLE: begin
          if (vox_valid && vox_ready) begin
            xyz_q       <= vox_xyz;
            chunk_idx_q <= '0;
            mem_en      <= 1'b1;
            mem_addr    <= {vox_xyz, CW'(0)};
            vox_ready   <= 1'b0;
            busy        <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (chunk_idx_q == CW'(NCH - 1)) begin
            mem_en  <= 1'b0;
            drain_q <= DCW'(RD_LAT);
            state_q <= ST_DRAIN;
          end else begin
            chunk_idx_q <= chunk_idx_q + CW'(1);
            mem_addr    <= {xyz_q, chunk_idx_q + CW'(1)};
          end
        end
        ST_DRAIN: begin
          // Counter reaching zero on this edge means the last word is present now
          if (drain_q == DCW'(1)) begin
            drain_q    <= '0;
            mask_q     <= chunk_fwd_c;
            mask_valid <= 1'b1;
            vox_cnt    <= sat_inc16(vox_cnt);
            state_q    <= ST_EMIT;
          end else begin
            drain_q <= drain_q - DCW'(1);
          end
        end
        ST_EMIT: begin
          vox_ready <= 1'b1;
          busy      <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          vox_ready <= 1'b1;
          busy      <= 1'b0;
          mem_en    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign edge_mask_512p0 = mask_q[0];
  assign edge_mask_512p1 = mask_q[1];
  assign edge_mask_512p2 = mask_q[2];
  assign edge_mask_512p3 = mask_q[3];
  assign edge_mask_512p4 = mask_q[4];
  assign edge_mask_512p5 = mask_q[5];
  assign edge_mask_512p6 = mask_q[6];
  assign edge_mask_512p7 = mask_q[7];

endmodule

// File: doc/prm_edge_mask_gen.md
Name: prm_edge_mask_gen

Overview:
- Upstream stage of the PRM edge-check accumulator.
- Accepts a stream of occupied-voxel coordinates {x,y,z} over a valid/ready handshake.
- For each voxel, fetches that voxel's 4096-bit edge-collision mask from an external fixed-latency memory as NCH words of MW bits.
- Presents the full mask on eight 512-bit chunk outputs for exactly one cycle. The downstream accumulator ORs those outputs every cycle, so the outputs are zero at all other times.

Parameters:
- XW, 4, x coordinate width
- YW, 5, y coordinate width
- ZW, 5, z coordinate width
- MW, 512, memory word / mask chunk width (fixed 512 in this revision)
- NCH, 8, chunks per voxel mask (fixed 8; chunk index width CW=3)
- RD_LAT, 2, memory read latency in cycles, legal range 1..7

Ports:
- CLK  in  1  clock
- RST_n  in  1  reset, asynchronous, active-low
- vox_valid  in  1  voxel coordinate valid
- vox_ready  out  1  block can accept a voxel
- vox_xyz  in  XW+YW+ZW  {x,y,z}, x in MSBs
- mem_en  out  1  memory read strobe
- mem_addr  out  XW+YW+ZW+CW  {x,y,z,chunk}
- mem_rdata  in  MW  read data, valid RD_LAT cycles after mem_en
- edge_mask_512p0..edge_mask_512p7  out  MW each  mask chunks 0..7
- mask_valid  out  1  high in the cycle the chunk outputs carry a mask
- busy  out  1  not IDLE
- vox_cnt  out  16  voxels emitted, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, synchronous release):
  - state IDLE, vox_ready=1, mem_en=0, mem_addr=0, all edge_mask outputs 0, mask_valid=0, busy=0, vox_cnt=0.
  - Tag pipeline and chunk registers are cleared.
- FSM states: IDLE, ISSUE, DRAIN, EMIT.
- IDLE:
  - vox_ready=1.
  - On vox_valid&&vox_ready, latch vox_xyz, clear the chunk index and go to ISSUE.
- ISSUE:
  - Lasts NCH cycles. Each cycle mem_en=1 and mem_addr={xyz_latched, k}, with k running 0..NCH-1.
  - After k=NCH-1, go to DRAIN with drain counter=RD_LAT.
- DRAIN:
  - mem_en=0. The counter decrements each cycle; at 0, go to EMIT.
- EMIT (one cycle):
  - Registered outputs edge_mask_512pk = chunk register k; mask_valid=1; vox_cnt increments (saturating).
  - Next state is IDLE.
- Outside EMIT, all edge_mask outputs and mask_valid are 0.
- Capture:
  - An RD_LAT-deep tag pipeline carries {en, k} alongside each read.
  - When the tag emerges with en=1, mem_rdata is written to chunk register k.
  - Capture runs independently of FSM state.
- Timing (RD_LAT=2, NCH=8):
  - handshake in cycle 0; mem_en in cycles 1..8; rdata in cycles 3..10; mask_valid in cycle 11; vox_ready high again in cycle 12.
  - Period is NCH+RD_LAT+2 cycles per voxel.
- vox_ready is high only in IDLE. A vox_valid held high during busy is not consumed.
- Each chunk register is overwritten in full for every voxel, so no stale data from a prior voxel can appear in EMIT.
- Reset mid-operation aborts immediately. In-flight reads are dropped because the tag pipeline is cleared, and no partial mask is ever emitted.
- Back-to-back voxels are accepted in the cycle after EMIT. There is no overlap between voxels.
- X/Z on vox_xyz while vox_valid=0 has no effect.

Decomposition:
- Shared package prm_pkg:
  - XW/YW/ZW defaults, CW=3, NCH=8, MW=512.
  - FSM state encoding (2-bit localparams).
- One sub-module, prm_tag_pipe: a parameterised RD_LAT-stage shift register of {en, chunk}, with async active-low reset.

Test Plan:
- Single voxel:
  - Stimulus: memory model returns word = {16{addr[16:0] zero-extended to 32}}. Reset, then drive vox_xyz=14'h1234 in cycle 0.
  - Required: mem_addr=17'h91A0..17'h91A7 in cycles 1..8; mask_valid only in cycle 11; edge_mask_512p3 = {16{32'h000091A3}}; vox_cnt=1.
- Outputs zero outside EMIT: edge_mask outputs are all zero in every cycle except cycle 11, checked by OR-reducing all 4096 bits each cycle.
- Backpressure and back-to-back:
  - Stimulus: hold vox_valid=1 with xyz=1, then xyz=2.
  - Required: second handshake in cycle 12; second mask_valid in cycle 23; vox_cnt=2; chunk contents match xyz=2 with no residue from xyz=1.
- Reset mid-operation:
  - Stimulus: assert RST_n=0 asynchronously in cycle 5.
  - Required: outputs at reset values immediately. After release, no mask_valid until a new voxel is accepted, and that voxel's mask is correct.
- Latency sweep: RD_LAT=1 gives mask_valid in cycle 10; RD_LAT=7 gives mask_valid in cycle 16. Contents are correct in both cases.
- Saturation: preload by forcing vox_cnt=16'hFFFE, run 3 voxels, and check vox_cnt ends at 16'hFFFF.
